bnn_sequencer: RTL and testbench
================================

Name: bnn_sequencer

Overview:
Host-side controller for the 8-8-4 BNN core, which loads weights through a nibble/load-enable pin protocol and computes through two registered layers. It accepts byte commands over a valid/ready interface and sequences two operations. The first is 2-cycle nibble weight loading for each of the 12 neurons. The second is inference: it presents the 8-bit input vector, waits out the 2-stage pipeline, and returns the 4-bit result on a valid/ready port. It sits between the host interface logic and the BNN core and drives all of the core's control pins.

Parameters:
NUM_NEURONS, 12, neurons whose weights are loadable (8 layer-1 + 4 layer-2)
PIPE_LAT, 2, core register stages from input vector to 4-bit output

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high; must be asserted together with the BNN core reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command this cycle
cmd_type  input  1  0 = weight byte for next neuron, 1 = inference
cmd_data  input  8  weight byte (bit i = weight for input i) or input vector
res_valid  output  1  inference result available
res_ready  input  1  host consumes result
res_data  output  4  layer-2 neuron outputs, bit k = neuron 8+k
bnn_ena  output  1  core enable
bnn_uio  output  8  core bidir-input drive: [7:4] weight nibble, [3] load_en, [2:0] zero
bnn_in  output  8  core ui_in vector
bnn_out  input  4  core uo_out[3:0]
load_count  output  4  neurons loaded since reset (0..NUM_NEURONS)
weights_full  output  1  load_count == NUM_NEURONS
err_overflow  output  1  sticky: weight byte received while weights_full

Behaviour:
- Reset values:
  - state IDLE; cmd_ready 1; res_valid 0; res_data 0; bnn_ena 0; bnn_uio 0; bnn_in 0; load_count 0; weights_full 0; err_overflow 0.
- bnn_ena goes to 1 on the first clk edge after reset deasserts and stays at 1.
- All outputs are registered. A handshake occurs on an edge where cmd_valid && cmd_ready.
- States: IDLE, LOAD_LO, LOAD_HI, INFER_WAIT, RESULT.
- cmd_ready = 1 only in IDLE.
- Weight load handshake at edge E0, with load_count < NUM_NEURONS:
  - E0: bnn_uio <= {cmd_data[3:0], 1, 000}; latch cmd_data[7:4]; state LOAD_LO.
  - E1 (the core captures the low nibble): bnn_uio <= {hi_nibble, 1, 000}; state LOAD_HI.
  - E2 (the core writes the full byte): bnn_uio <= 0; load_count++; state IDLE.
  - Exactly 2 cycles with load_en high per neuron. Never 1 or 3, because an odd count desynchronises the core's nibble phase.
- Weight byte while weights_full:
  - Command is consumed (handshake completes).
  - load_en is not pulsed; err_overflow <= 1.
  - State stays IDLE, so the core's neuron index never wraps past 11.
- Inference handshake at edge E0:
  - bnn_in <= cmd_data; wait counter <= 0; state INFER_WAIT.
  - Counter increments each cycle. When it reaches PIPE_LAT, at edge E(PIPE_LAT+1): res_data <= bnn_out; res_valid <= 1; state RESULT.
  - Latency from handshake edge to res_valid high is PIPE_LAT+1 edges (3 by default).
  - bnn_in holds its value until the next inference handshake.
- Inference is permitted with load_count < NUM_NEURONS. The core then uses its reset default weights for unloaded neurons; no error is flagged.
- RESULT state:
  - res_valid and res_data are held stable until res_valid && res_ready at an edge.
  - At that edge: res_valid <= 0; state IDLE.
  - cmd_ready is 0 throughout, so no command is accepted while a result is pending.
  - res_ready while res_valid = 0 is ignored.
- bnn_uio[3] is never high outside LOAD_LO/LOAD_HI.
- cmd_valid may drop or cmd_data may change while cmd_ready = 0 without effect.
- err_overflow clears only on reset.
- Reset mid-operation (any state, any cycle):
  - Immediate return to all reset values.
  - A partial nibble load is abandoned. This is safe only because the core is reset simultaneously, which is a system requirement.

Test Plan:
1. Reset, then 12 weight bytes 0x01..0x0C back-to-back with cmd_valid held high. Required: each accepted every 3 cycles; bnn_uio[3] high exactly 2 cycles per byte; bnn_uio[7:4] = 1,0,2,0,...,C,0; load_count 1..12; weights_full = 1 after the 12th.
2. After scenario 1, a 13th weight byte 0xFF. Required: accepted; bnn_uio stays 0; load_count stays 12; err_overflow = 1 and remains set.
3. Reset, no weights loaded, inference with cmd_data = 0xE0, bnn_out model returning 4'b1010 two edges after bnn_in changes. Required: res_valid rises 3 edges after the handshake; res_data = 1010; bnn_in = 0xE0.
4. Inference with res_ready held 0 for 5 cycles while a second command is pending. Required: res_valid/res_data stable; cmd_ready = 0; second command accepted on the edge after res_ready = 1 completes the result handshake.
5. Assert reset during LOAD_HI of the 5th neuron. Required: bnn_uio = 0 and load_count = 0 immediately (asynchronous); cmd_ready = 1 after reset release; a subsequent load begins at neuron 0.
6. Interleave: weight byte, inference 0xFF, weight byte. Required: load_count goes 1 then 2; inference bnn_in = 0xFF; no bnn_uio[3] activity during INFER_WAIT/RESULT.

Source files
------------

// File: rtl/bnn_sequencer_if.sv
// Host-side command and result channels of the BNN sequencer.
// Combinational bundle only; no storage or latency of its own.
// Both channels use valid/ready; the sequencer side owns cmd_ready and res_valid.
interface bnn_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_type;
  logic [7:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;

  modport master (
    output cmd_valid, cmd_type, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/bnn_sequencer.sv
// Drives the 8-8-4 BNN core pins: 2-cycle nibble weight loads and pipelined inference.
// Weight load occupies 3 cycles; inference result appears PIPE_LAT+1 edges after the command.
// cmd_ready only in IDLE; a pending result stalls all new commands until res_ready.
module bnn_sequencer #(
  parameter int NUM_NEURONS = 12,
  parameter int PIPE_LAT    = 2
) (
  input  logic                clk,
  input  logic                reset,
  bnn_sequencer_if.slave      host,
  output logic                bnn_ena,
  output logic [7:0]          bnn_uio,
  output logic [7:0]          bnn_in,
  input  logic [3:0]          bnn_out,
  output logic [3:0]          load_count,
  output logic                weights_full,
  output logic                err_overflow
);

  localparam int CW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    INFER_WAIT,
    RESULT
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           cmd_hs;
  logic           wait_done;
  logic [3:0]     hi_nib;
  logic [CW-1:0]  wait_cnt;

  assign cmd_hs    = host.cmd_valid && host.cmd_ready;
  assign wait_done = (wait_cnt == CW'(PIPE_LAT));

  // State register; reset abandons any half-finished nibble load (core is reset alongside).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: overflowing weight bytes are consumed but keep us in IDLE so the core index never wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          if (host.cmd_type) begin
            state_nxt = INFER_WAIT;
          end else if (!weights_full) begin
            state_nxt = LOAD_LO;
          end
        end
      end
      LOAD_LO:    state_nxt = LOAD_HI;
      LOAD_HI:    state_nxt = IDLE;
      INFER_WAIT: if (wait_done) state_nxt = RESULT;
      RESULT:     if (host.res_ready) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Registered outputs: pin drive, counters, result capture and handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host.cmd_ready <= 1'b1;
      host.res_valid <= 1'b0;
      host.res_data  <= 4'd0;
      bnn_ena        <= 1'b0;
      bnn_uio        <= 8'd0;
      bnn_in         <= 8'd0;
      load_count     <= 4'd0;
      weights_full   <= 1'b0;
      err_overflow   <= 1'b0;
      hi_nib         <= 4'd0;
      wait_cnt       <= '0;
    end else begin
      bnn_ena        <= 1'b1;
      host.cmd_ready <= (state_nxt == IDLE);
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            if (host.cmd_type) begin
              bnn_in   <= host.cmd_data;
              wait_cnt <= '0;
            end else if (!weights_full) begin
              // Low nibble first with load_en; high nibble is parked for the next cycle.
              bnn_uio <= {host.cmd_data[3:0], 4'b1000};
              hi_nib  <= host.cmd_data[7:4];
            end else begin
              err_overflow <= 1'b1;
            end
          end
        end
        LOAD_LO: begin
          bnn_uio <= {hi_nib, 4'b1000};
        end
        LOAD_HI: begin
          bnn_uio      <= 8'd0;
          load_count   <= load_count + 4'd1;
          weights_full <= (load_count == 4'(NUM_NEURONS - 1));
        end
        INFER_WAIT: begin
          if (wait_done) begin
            host.res_data  <= bnn_out;
            host.res_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESULT: begin
          if (host.res_ready) begin
            host.res_valid <= 1'b0;
          end
        end
        default: begin
          bnn_uio <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_sequencer.sv
`timescale 1ns/1ps
module tb_bnn_sequencer;
  localparam int CLK = 10;
  localparam int NN  = 12;
  localparam int PL  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #(CLK/2) clk = ~clk;

  bnn_sequencer_if host();
  logic       bnn_ena;
  logic [7:0] bnn_uio;
  logic [7:0] bnn_in;
  logic [3:0] bnn_out;
  logic [3:0] load_count;
  logic       weights_full;
  logic       err_overflow;

  bnn_sequencer #(.NUM_NEURONS(NN), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .host(host),
    .bnn_ena(bnn_ena), .bnn_uio(bnn_uio), .bnn_in(bnn_in), .bnn_out(bnn_out),
    .load_count(load_count), .weights_full(weights_full), .err_overflow(err_overflow)
  );

  // Stand-in core: two register stages from bnn_in, then a fixed 8->4 function.
  function automatic logic [3:0] core_f(input logic [7:0] v);
    return v[7:4] ^ v[3:0] ^ 4'b0100;
  endfunction
  logic [7:0] core_s1, core_s2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_s1 <= 8'd0;
      core_s2 <= 8'd0;
    end else begin
      core_s1 <= bnn_in;
      core_s2 <= core_s1;
    end
  end
  assign bnn_out = core_f(core_s2);

  int n_tests = 0;
  int n_fail  = 0;
  time hs_t = 0, prev_hs = 0, res_t = 0;
  int m_cnt = 0;
  bit m_err = 0;
  logic [7:0] last_in = 8'd0;

  typedef struct {
    bit         do_reset;
    bit         b2b;
    bit         ovf;
    bit         typ;
    logic [7:0] data;
    int         hold;
    logic [3:0] exp_lc;
    bit         exp_full;
    bit         exp_err;
    logic [3:0] exp_res;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    host.cmd_valid = 1'b0;
    host.res_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_uio", 32'(bnn_uio), 0);
    chk("rst_load_count", 32'(load_count), 0);
    chk("rst_cmd_ready", 32'(host.cmd_ready), 1);
    chk("rst_res_valid", 32'(host.res_valid), 0);
    chk("rst_res_data", 32'(host.res_data), 0);
    chk("rst_ena", 32'(bnn_ena), 0);
    chk("rst_bnn_in", 32'(bnn_in), 0);
    chk("rst_full", 32'(weights_full), 0);
    chk("rst_err", 32'(err_overflow), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ena_before_edge", 32'(bnn_ena), 0);
    @(negedge clk);
    chk("ena_after_edge", 32'(bnn_ena), 1);
    m_cnt = 0;
    m_err = 0;
    last_in = 8'd0;
  endtask

  // Present a command, wait (bounded) for the handshake edge, then scramble or drop it.
  task automatic issue(input bit t, input logic [7:0] d, input bit hold_after);
    int n = 0;
    host.cmd_valid = 1'b1;
    host.cmd_type  = t;
    host.cmd_data  = d;
    while (host.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (host.cmd_ready !== 1'b1) chk("hs_timeout", 32'(host.cmd_ready), 1);
    @(posedge clk);
    prev_hs = hs_t;
    hs_t = $time;
    #1;
    if (hold_after) begin
      host.cmd_type = 1'($urandom);
      host.cmd_data = 8'($urandom);
    end else begin
      host.cmd_valid = 1'b0;
    end
  endtask

  task automatic chk_weight(input logic [7:0] d, input bit ovf, input logic [3:0] exp_lc,
                            input bit exp_full, input bit exp_err);
    if (!ovf) begin
      @(negedge clk);
      chk("uio_lo_nibble", 32'(bnn_uio), 32'({d[3:0], 4'b1000}));
      chk("ready_during_load", 32'(host.cmd_ready), 0);
      @(negedge clk);
      chk("uio_hi_nibble", 32'(bnn_uio), 32'({d[7:4], 4'b1000}));
      @(negedge clk);
      chk("uio_after_load", 32'(bnn_uio), 0);
    end else begin
      @(negedge clk);
      chk("ovf_no_load", 32'(bnn_uio), 0);
    end
    chk("load_count", 32'(load_count), 32'(exp_lc));
    chk("weights_full", 32'(weights_full), 32'(exp_full));
    chk("err_overflow", 32'(err_overflow), 32'(exp_err));
    chk("ready_after_w", 32'(host.cmd_ready), 1);
    chk("bnn_in_holds", 32'(bnn_in), 32'(last_in));
  endtask

  task automatic chk_infer(input logic [7:0] d, input logic [3:0] exp_res, input logic [3:0] exp_lc,
                           input bit exp_err, input int hold,
                           input bit nv, input bit nt, input logic [7:0] nd);
    int edges = 0;
    host.res_ready = 1'($urandom);
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      chk("infer_wait_uio", 32'(bnn_uio), 0);
    end while (host.res_valid !== 1'b1 && edges < 10);
    host.res_ready = 1'b0;
    chk("infer_latency", 32'(edges), 32'(PL + 1));
    chk("res_valid", 32'(host.res_valid), 1);
    chk("res_data", 32'(host.res_data), 32'(exp_res));
    chk("bnn_in", 32'(bnn_in), 32'(d));
    chk("ready_in_result", 32'(host.cmd_ready), 0);
    chk("lc_in_infer", 32'(load_count), 32'(exp_lc));
    chk("err_in_infer", 32'(err_overflow), 32'(exp_err));
    repeat (hold) begin
      @(negedge clk);
      chk("res_hold_valid", 32'(host.res_valid), 1);
      chk("res_hold_data", 32'(host.res_data), 32'(exp_res));
      chk("res_hold_ready", 32'(host.cmd_ready), 0);
      chk("res_hold_uio", 32'(bnn_uio), 0);
    end
    host.cmd_valid = nv;
    host.cmd_type  = nt;
    host.cmd_data  = nd;
    host.res_ready = 1'b1;
    @(posedge clk);
    res_t = $time;
    #1;
    host.res_ready = 1'($urandom);
    @(negedge clk);
    chk("res_valid_clear", 32'(host.res_valid), 0);
    chk("ready_after_res", 32'(host.cmd_ready), 1);
    last_in = d;
  endtask

  initial begin
    #(50000 * CLK);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit ovf;
    host.cmd_valid = 1'b0;
    host.cmd_type  = 1'b0;
    host.cmd_data  = 8'd0;
    host.res_ready = 1'b0;

    // Twelve back-to-back weights, one overflow, then reset + weight/infer/weight interleave.
    for (int i = 0; i < 12; i++)
      vecs[i] = '{(i == 0), (i > 0), 1'b0, 1'b0, 8'(i + 1), 0, 4'(i + 1), (i == 11), 1'b0, 4'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 0, 4'd12, 1'b1, 1'b1, 4'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 0, 4'd1, 1'b0, 1'b0, 4'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 2, 4'd1, 1'b0, 1'b0, 4'b0100};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 4'd2, 1'b0, 1'b0, 4'd0};

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].do_reset) do_reset();
      if (!vecs[i].typ) begin
        issue(1'b0, vecs[i].data, !vecs[i].ovf);
        if (vecs[i].b2b) chk("b2b_spacing", 32'(hs_t - prev_hs), 32'(3 * CLK));
        chk_weight(vecs[i].data, vecs[i].ovf, vecs[i].exp_lc, vecs[i].exp_full, vecs[i].exp_err);
      end else begin
        issue(1'b1, vecs[i].data, 1'b1);
        chk_infer(vecs[i].data, vecs[i].exp_res, vecs[i].exp_lc, vecs[i].exp_err,
                  vecs[i].hold, 1'b0, 1'b0, 8'd0);
      end
    end

    // Inference with no weights loaded.
    do_reset();
    issue(1'b1, 8'hE0, 1'b1);
    chk_infer(8'hE0, 4'b1010, 4'd0, 1'b0, 0, 1'b0, 1'b0, 8'd0);

    // Result held back 5 cycles while a weight command waits behind it.
    issue(1'b1, 8'h3C, 1'b1);
    chk_infer(8'h3C, 4'b1011, 4'd0, 1'b0, 5, 1'b1, 1'b0, 8'h33);
    issue(1'b0, 8'h33, 1'b1);
    chk("pending_cmd_edge", 32'(hs_t - res_t), 32'(CLK));
    chk_weight(8'h33, 1'b0, 4'd1, 1'b0, 1'b0);

    // Reset during the high-nibble cycle of the 5th neuron.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 8'(8'h10 + i), 1'b1);
      chk_weight(8'(8'h10 + i), 1'b0, 4'(i + 1), 1'b0, 1'b0);
    end
    issue(1'b0, 8'hC7, 1'b0);
    @(negedge clk);
    chk("mid_lo", 32'(bnn_uio), 32'h78);
    @(negedge clk);
    chk("mid_hi", 32'(bnn_uio), 32'hC8);
    reset = 1'b1;
    #1;
    chk("async_uio", 32'(bnn_uio), 0);
    chk("async_lc", 32'(load_count), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rel", 32'(host.cmd_ready), 1);
    last_in = 8'd0;
    issue(1'b0, 8'h21, 1'b1);
    chk_weight(8'h21, 1'b0, 4'd1, 1'b0, 1'b0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
      end else if (r < 10) begin
        host.cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end else if (r < 55) begin
        d = 8'($urandom);
        ovf = (m_cnt == NN);
        issue(1'b0, d, !ovf);
        if (ovf) m_err = 1'b1;
        else m_cnt++;
        chk_weight(d, ovf, 4'(m_cnt), (m_cnt == NN), m_err);
      end else begin
        d = 8'($urandom);
        issue(1'b1, d, 1'b1);
        chk_infer(d, core_f(d), 4'(m_cnt), m_err, $urandom_range(0, 3), 1'b0, 1'b0, 8'd0);
      end
    end

    host.cmd_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
